spi_logic_slave: RTL and testbench

SPI responder (slave) that lets the RISC-V SoC be the target of an external SPI master, the counterpart to the team's SPI master logic. Runs entirely in the `clk_cpu` domain and oversamples the external SCK, MOSI and SS pins through two-flop synchronizers. Fixed SPI mode 0 (CPOL=0, CPHA=0), MSB first, with 8/16/24/32-bit words. Transfers are back-to-back under one SS assertion. One-word TX buffer, one-word RX holding register, and a sticky interrupt toward the CPU register file.

---
 rtl/spi_logic_slave_if.sv | 23 ++
 rtl/spi_logic_slave.sv | 162 ++++++++++++++++
 tb/tb_spi_logic_slave.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_logic_slave_if.sv
// CPU-side register interface of the SPI responder: configuration, TX buffer
// load, RX word readback and interrupt status.
interface spi_logic_slave_if;
    logic        SPI_EN;
    logic [1:0]  SPI_DATA_LEN;
    logic [31:0] SPI_DATA_OUT;
    logic        SPI_TX_LOAD;
    logic        SPI_IRQ_CLR;
    logic [31:0] SPI_DATA_IN;
    logic        IRQ_SPI;
    logic        SPI_OVERRUN;
    logic        TX_EMPTY;

    modport master (
        output SPI_EN, SPI_DATA_LEN, SPI_DATA_OUT, SPI_TX_LOAD, SPI_IRQ_CLR,
        input  SPI_DATA_IN, IRQ_SPI, SPI_OVERRUN, TX_EMPTY
    );

    modport slave (
        input  SPI_EN, SPI_DATA_LEN, SPI_DATA_OUT, SPI_TX_LOAD, SPI_IRQ_CLR,
        output SPI_DATA_IN, IRQ_SPI, SPI_OVERRUN, TX_EMPTY
    );
endinterface

// File: rtl/spi_logic_slave.sv
// SPI mode-0 responder, MSB first, 8/16/24/32-bit words, oversampling the
// external pins in the clk_cpu domain.
module spi_logic_slave (
    input  logic              clk_cpu,
    input  logic              rst,
    spi_logic_slave_if.slave  bus,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              SS,
    output logic              MISO,
    output logic              MISO_OE
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t      state;
    logic [2:0]  sck_sync;
    logic [2:0]  ss_sync;
    logic [1:0]  mosi_sync;

    logic [1:0]  len_q;
    logic [31:0] tx_buf;
    logic        tx_empty;
    logic [30:0] tx_shift;
    logic [30:0] rx_shift;
    logic [5:0]  bit_cnt;
    logic        rise_seen;
    logic [31:0] data_in;
    logic        irq;
    logic        overrun;
    logic        miso_q;
    logic        miso_oe_q;

    logic        sck_rise, sck_fall, ss_fall, ss_rise, mosi_bit;
    logic [5:0]  n_bits;
    logic [5:0]  cnt_nxt;
    logic        word_done;
    logic [31:0] rx_nxt;
    logic [31:0] tx_nxt;
    logic [31:0] tx_load_val;
    logic [31:0] len_mask;
    logic [4:0]  msb_idx;
    logic [4:0]  load_msb_idx;

    // SS resets high so a select held across reset release is not seen as a fall
    always_ff @(posedge clk_cpu or negedge rst) begin
        if (!rst) begin
            sck_sync  <= 3'b000;
            ss_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[1:0], SCK};
            ss_sync   <= {ss_sync[1:0], SS};
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign ss_fall  = ~ss_sync[1] & ss_sync[2];
    assign ss_rise  = ss_sync[1] & ~ss_sync[2];
    assign mosi_bit = mosi_sync[1];

    assign n_bits       = {1'b0, len_q, 3'b000} + 6'd8;
    assign cnt_nxt      = bit_cnt + 6'd1;
    assign word_done    = (state == SHIFT) && sck_rise && !ss_rise && (cnt_nxt == n_bits);
    assign rx_nxt       = {rx_shift, mosi_bit};
    assign tx_nxt       = {tx_shift, 1'b0};
    assign tx_load_val  = tx_empty ? 32'h0 : tx_buf;
    assign msb_idx      = {len_q, 3'b111};
    assign load_msb_idx = {bus.SPI_DATA_LEN, 3'b111};

    always_comb begin
        len_mask = 32'hFFFF_FFFF;
        case (len_q)
            2'd0:    len_mask = 32'h0000_00FF;
            2'd1:    len_mask = 32'h0000_FFFF;
            2'd2:    len_mask = 32'h00FF_FFFF;
            default: len_mask = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= 2'd0;
            tx_buf    <= 32'h0;
            tx_empty  <= 1'b1;
            tx_shift  <= 31'h0;
            rx_shift  <= 31'h0;
            bit_cnt   <= 6'd0;
            rise_seen <= 1'b0;
            data_in   <= 32'h0;
            irq       <= 1'b0;
            overrun   <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
        end else begin
            if (ss_rise) begin
                // deselect abandons any partial word; the TX buffer stays consumed
                state     <= IDLE;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_fall && bus.SPI_EN)
                            state <= LOAD;
                    end
                    LOAD: begin
                        len_q     <= bus.SPI_DATA_LEN;
                        tx_shift  <= tx_load_val[30:0];
                        tx_empty  <= 1'b1;
                        rx_shift  <= 31'h0;
                        bit_cnt   <= 6'd0;
                        rise_seen <= 1'b0;
                        miso_q    <= tx_load_val[load_msb_idx];
                        miso_oe_q <= 1'b1;
                        state     <= SHIFT;
                    end
                    SHIFT: begin
                        if (sck_rise) begin
                            rx_shift  <= rx_nxt[30:0];
                            bit_cnt   <= cnt_nxt;
                            rise_seen <= 1'b1;
                            if (word_done)
                                state <= bus.SPI_EN ? LOAD : IDLE;
                        end else if (sck_fall && rise_seen) begin
                            // a fall before the word's first rise is the previous word's tail
                            tx_shift <= tx_nxt[30:0];
                            miso_q   <= tx_nxt[msb_idx];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // a write in the LOAD cycle lands in the buffer after it was copied out
            if (bus.SPI_TX_LOAD) begin
                tx_buf   <= bus.SPI_DATA_OUT;
                tx_empty <= 1'b0;
            end

            if (bus.SPI_IRQ_CLR) begin
                irq     <= 1'b0;
                overrun <= 1'b0;
            end
            if (word_done) begin
                data_in <= rx_nxt & len_mask;
                irq     <= 1'b1;
                if (irq && !bus.SPI_IRQ_CLR)
                    overrun <= 1'b1;
            end
        end
    end

    assign bus.SPI_DATA_IN = data_in;
    assign bus.IRQ_SPI     = irq;
    assign bus.SPI_OVERRUN = overrun;
    assign bus.TX_EMPTY    = tx_empty;
    assign MISO            = miso_q;
    assign MISO_OE         = miso_oe_q;
endmodule

// File: tb/tb_spi_logic_slave.sv
// Scoreboard bench for spi_logic_slave: an SPI master task drives the pins,
// a word-level model predicts MISO streams and RX words, a monitor checks them.
module tb_spi_logic_slave;
    localparam int H = 5;

    logic clk_cpu = 1'b0;
    logic rst = 1'b0;
    logic SCK = 1'b0, MOSI = 1'b0, SS = 1'b1;
    logic MISO, MISO_OE;

    spi_logic_slave_if bus();

    spi_logic_slave dut (
        .clk_cpu (clk_cpu),
        .rst     (rst),
        .bus     (bus),
        .SCK     (SCK),
        .MOSI    (MOSI),
        .SS      (SS),
        .MISO    (MISO),
        .MISO_OE (MISO_OE)
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct packed {
        logic [31:0] data;
        logic        ovr;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // word-level model state
    logic        m_irq = 1'b0, m_ovr = 1'b0, m_full = 1'b0;
    logic [31:0] m_buf = 32'h0, m_data = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input int nb);
        return (nb >= 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
    endfunction

    function automatic logic [31:0] rand_rx(input int nb);
        logic [31:0] r;
        do r = $urandom & mask_of(nb); while (r == m_data);
        return r;
    endfunction

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk_cpu);
    endtask

    task automatic tx_load(input logic [31:0] v);
        bus.SPI_DATA_OUT = v;
        bus.SPI_TX_LOAD  = 1'b1;
        @(negedge clk_cpu);
        bus.SPI_TX_LOAD  = 1'b0;
        m_buf  = v;
        m_full = 1'b1;
    endtask

    task automatic irq_clear();
        bus.SPI_IRQ_CLR = 1'b1;
        @(negedge clk_cpu);
        bus.SPI_IRQ_CLR = 1'b0;
        m_irq = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic next_tx(input int nb, output logic [31:0] t);
        t = m_full ? (m_buf & mask_of(nb)) : 32'h0;
        m_full = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] rx, input int nb, input bit race);
        exp_t e;
        if (race) begin
            m_irq = 1'b0;
            m_ovr = 1'b0;
        end
        e.data = rx & mask_of(nb);
        e.ovr  = m_ovr | m_irq;
        m_irq  = 1'b1;
        m_ovr  = e.ovr;
        m_data = e.data;
        sbq.push_back(e);
    endtask

    // master side: nclk bits of an nb-bit word, MSB first, MISO sampled at each rise
    task automatic run_word(input logic [31:0] mo, input int nb, input int nclk, input bit ld,
                            input logic [31:0] ldv, input bit race, output logic [31:0] got);
        got = 32'h0;
        for (int i = 0; i < nclk; i++) begin
            MOSI = mo[nb-1-i];
            for (int j = 0; j < H; j++) begin
                @(negedge clk_cpu);
                bus.SPI_DATA_OUT = ldv;
                bus.SPI_TX_LOAD  = (ld && i == 2 && j == 0);
            end
            SCK = 1'b1;
            got[nb-1-i] = MISO;
            for (int j = 0; j < H; j++) begin
                @(negedge clk_cpu);
                bus.SPI_IRQ_CLR = (race && i == nclk-1 && j == 1);
            end
            SCK = 1'b0;
        end
    endtask

    task automatic word(input logic [31:0] rx, input int nb, input bit ld,
                        input logic [31:0] ldv, input bit race, input string tag);
        logic [31:0] exp_tx, got;
        next_tx(nb, exp_tx);
        expect_word(rx, nb, race);
        run_word(rx, nb, nb, ld, ldv, race, got);
        check(tag, got, exp_tx);
        if (ld) begin
            m_buf  = ldv;
            m_full = 1'b1;
        end
    endtask

    task automatic xfer_begin();
        SS = 1'b0;
        clk_n(8);
    endtask

    task automatic xfer_end();
        clk_n(4);
        SS = 1'b1;
        clk_n(3);
        check("miso_oe_off", 32'(MISO_OE), 32'd0);
        clk_n(3);
    endtask

    task automatic check_reset_outputs();
        check("rst_data_in", bus.SPI_DATA_IN, 32'h0);
        check("rst_irq", 32'(bus.IRQ_SPI), 32'd0);
        check("rst_overrun", 32'(bus.SPI_OVERRUN), 32'd0);
        check("rst_tx_empty", 32'(bus.TX_EMPTY), 32'd1);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_miso_oe", 32'(MISO_OE), 32'd0);
    endtask

    // monitor: a new RX word is an IRQ rise, or a data change while IRQ is held
    initial begin
        logic        irq_p;
        logic [31:0] d_p;
        exp_t        e;
        irq_p = 1'b0;
        d_p   = 32'h0;
        forever begin
            @(negedge clk_cpu);
            if (rst && bus.IRQ_SPI && (!irq_p || bus.SPI_DATA_IN != d_p)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", bus.SPI_DATA_IN);
                end else begin
                    e = sbq.pop_front();
                    check("rx_data", bus.SPI_DATA_IN, e.data);
                    check("overrun", 32'(bus.SPI_OVERRUN), 32'(e.ovr));
                end
            end
            irq_p = bus.IRQ_SPI;
            d_p   = bus.SPI_DATA_IN;
        end
    end

    initial begin
        #600us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          len, nb, nw;
        bit          ld;
        logic [31:0] rx, ldv, got, dummy, ra, rb;

        bus.SPI_EN       = 1'b1;
        bus.SPI_DATA_LEN = 2'd0;
        bus.SPI_DATA_OUT = 32'h0;
        bus.SPI_TX_LOAD  = 1'b0;
        bus.SPI_IRQ_CLR  = 1'b0;
        clk_n(3);
        check_reset_outputs();
        rst = 1'b1;
        clk_n(3);

        // 8-bit exchange
        bus.SPI_DATA_LEN = 2'd0;
        tx_load(32'hA5);
        check("tx_empty_loaded", 32'(bus.TX_EMPTY), 32'd0);
        xfer_begin();
        check("miso_oe_on", 32'(MISO_OE), 32'd1);
        word(32'h3C, 8, 1'b0, 32'h0, 1'b0, "miso_8b");
        check("irq_8b", 32'(bus.IRQ_SPI), 32'd1);
        check("tx_empty_8b", 32'(bus.TX_EMPTY), 32'd1);
        check("data_8b", bus.SPI_DATA_IN, 32'h3C);
        xfer_end();
        irq_clear();

        // 32-bit back-to-back, second word reloaded mid-first-word, IRQ left set
        bus.SPI_DATA_LEN = 2'd3;
        tx_load(32'hDEADBEEF);
        xfer_begin();
        word(32'hCAFEF00D, 32, 1'b1, 32'h12345678, 1'b0, "miso_w1");
        word(32'h0BADF00D, 32, 1'b0, 32'h0, 1'b0, "miso_w2");
        check("overrun_b2b", 32'(bus.SPI_OVERRUN), 32'd1);
        check("data_b2b", bus.SPI_DATA_IN, 32'h0BADF00D);
        xfer_end();
        irq_clear();
        check("irq_cleared", 32'(bus.IRQ_SPI), 32'd0);
        check("overrun_cleared", 32'(bus.SPI_OVERRUN), 32'd0);

        // underrun: no load, MISO all zeros
        bus.SPI_DATA_LEN = 2'd1;
        xfer_begin();
        word(rand_rx(16), 16, 1'b0, 32'h0, 1'b0, "miso_underrun");
        xfer_end();
        irq_clear();

        // abort after 5 of 8 bits
        bus.SPI_DATA_LEN = 2'd0;
        tx_load(32'h5A);
        xfer_begin();
        next_tx(8, dummy);
        run_word(32'h96, 8, 5, 1'b0, 32'h0, 1'b0, got);
        check("miso_abort", got, 32'h58);
        SS = 1'b1;
        clk_n(3);
        check("oe_abort", 32'(MISO_OE), 32'd0);
        check("irq_abort", 32'(bus.IRQ_SPI), 32'd0);
        check("data_abort", bus.SPI_DATA_IN, m_data);
        check("tx_empty_abort", 32'(bus.TX_EMPTY), 32'd1);
        clk_n(3);
        tx_load(32'hC3);
        xfer_begin();
        word(rand_rx(8), 8, 1'b0, 32'h0, 1'b0, "miso_after_abort");
        xfer_end();
        irq_clear();

        // reset in the middle of a 24-bit word
        bus.SPI_DATA_LEN = 2'd2;
        tx_load(32'hABCDEF);
        xfer_begin();
        next_tx(24, dummy);
        run_word(32'h123456, 24, 12, 1'b0, 32'h0, 1'b0, got);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        SS = 1'b1;
        clk_n(2);
        rst = 1'b1;
        m_irq = 1'b0; m_ovr = 1'b0; m_full = 1'b0; m_data = 32'h0;
        clk_n(4);

        // disabled block ignores select
        bus.SPI_EN = 1'b0;
        bus.SPI_DATA_LEN = 2'd0;
        xfer_begin();
        check("oe_disabled", 32'(MISO_OE), 32'd0);
        run_word(32'hFF, 8, 8, 1'b0, 32'h0, 1'b0, got);
        clk_n(4);
        check("irq_disabled", 32'(bus.IRQ_SPI), 32'd0);
        SS = 1'b1;
        clk_n(4);
        bus.SPI_EN = 1'b1;

        // clear pulse coincides with word done
        bus.SPI_DATA_LEN = 2'd0;
        xfer_begin();
        ra = rand_rx(8);
        word(ra, 8, 1'b0, 32'h0, 1'b0, "miso_race_a");
        rb = rand_rx(8);
        word(rb, 8, 1'b0, 32'h0, 1'b1, "miso_race_b");
        check("irq_race", 32'(bus.IRQ_SPI), 32'd1);
        check("overrun_race", 32'(bus.SPI_OVERRUN), 32'd0);
        xfer_end();
        irq_clear();

        // randomized transfers
        for (int t = 0; t < 15; t++) begin
            len = int'($urandom_range(0, 3));
            nb  = 8 * (len + 1);
            nw  = int'($urandom_range(1, 3));
            bus.SPI_DATA_LEN = 2'(len);
            if ($urandom_range(0, 1) == 1) tx_load($urandom);
            xfer_begin();
            for (int w = 0; w < nw; w++) begin
                ld  = (w < nw - 1) && ($urandom_range(0, 1) == 1);
                ldv = $urandom;
                rx  = rand_rx(nb);
                word(rx, nb, ld, ldv, 1'b0, "miso_rand");
            end
            xfer_end();
            if ($urandom_range(0, 1) == 1) irq_clear();
        end

        clk_n(10);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
